mem_port_arbiter: RTL and testbench

- Shares the single-port program/data memory system between two requesters: the instruction fetch (IF) port and the data (D) port of the multicycle core.
- Arbitrates round-robin, registers the winning request for one ACCESS cycle toward the memory, then returns registered read data or a write acknowledge.
- Sits between the core's fetch/load-store logic and the memory system's Write_Enable_i/Address_i/Write_Data/Read_Data pins.

---
 rtl/mem_port_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-port memory between the IF and D ports.
// Optional macro MEM_ARB_PERF_EN adds saturating conflict/grant counters.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]           conflict_cnt_o,
    output logic [15:0]           if_cnt_o,
    output logic [15:0]           d_cnt_o
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t                  state_r, state_s;
    logic                    owner_d_r, owner_d_s;
    logic                    last_d_r, last_d_s;
    logic                    pick_d_s;
    logic                    we_r, we_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
    logic [DATA_WIDTH-1:0]   wdata_r, wdata_s;
    logic                    if_gnt_r, if_gnt_s;
    logic                    d_gnt_r, d_gnt_s;
    logic                    if_rvalid_r, if_rvalid_s;
    logic                    d_rvalid_r, d_rvalid_s;
    logic [DATA_WIDTH-1:0]   if_rdata_r, if_rdata_s;
    logic [DATA_WIDTH-1:0]   d_rdata_r, d_rdata_s;
    logic                    busy_r, busy_s;

    // D wins when alone, or on a tie when IF had the previous grant.
    assign pick_d_s = d_req_i && (!if_req_i || !last_d_r);

    // Next-state and next-output logic for the IDLE/ACCESS FSM.
    always_comb begin
        state_s     = state_r;
        owner_d_s   = owner_d_r;
        last_d_s    = last_d_r;
        we_s        = 1'b0;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        if_gnt_s    = 1'b0;
        d_gnt_s     = 1'b0;
        if_rvalid_s = 1'b0;
        d_rvalid_s  = 1'b0;
        if_rdata_s  = if_rdata_r;
        d_rdata_s   = d_rdata_r;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (if_req_i || d_req_i) begin
                    state_s   = ST_ACCESS;
                    owner_d_s = pick_d_s;
                    last_d_s  = pick_d_s;
                    busy_s    = 1'b1;
                    if (pick_d_s) begin
                        d_gnt_s = 1'b1;
                        we_s    = d_we_i;
                        addr_s  = d_addr_i;
                        wdata_s = d_wdata_i;
                    end else begin
                        // IF carries no write data; drive zeros so the bus is deterministic.
                        if_gnt_s = 1'b1;
                        we_s     = 1'b0;
                        addr_s   = if_addr_i;
                        wdata_s  = {DATA_WIDTH{1'b0}};
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_s = ST_IDLE;
                if (owner_d_r) begin
                    d_rvalid_s = 1'b1;
                    if (!we_r) begin
                        d_rdata_s = mem_rdata_i;
                    end else begin
                        d_rdata_s = d_rdata_r;
                    end
                end else begin
                    if_rvalid_s = 1'b1;
                    if_rdata_s  = mem_rdata_i;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset also kills an in-flight write enable.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_r     <= ST_IDLE;
            owner_d_r   <= 1'b0;
            last_d_r    <= 1'b1;
            we_r        <= 1'b0;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            wdata_r     <= {DATA_WIDTH{1'b0}};
            if_gnt_r    <= 1'b0;
            d_gnt_r     <= 1'b0;
            if_rvalid_r <= 1'b0;
            d_rvalid_r  <= 1'b0;
            if_rdata_r  <= {DATA_WIDTH{1'b0}};
            d_rdata_r   <= {DATA_WIDTH{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            owner_d_r   <= owner_d_s;
            last_d_r    <= last_d_s;
            we_r        <= we_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            if_gnt_r    <= if_gnt_s;
            d_gnt_r     <= d_gnt_s;
            if_rvalid_r <= if_rvalid_s;
            d_rvalid_r  <= d_rvalid_s;
            if_rdata_r  <= if_rdata_s;
            d_rdata_r   <= d_rdata_s;
            busy_r      <= busy_s;
        end
    end

    assign if_gnt_o    = if_gnt_r;
    assign d_gnt_o     = d_gnt_r;
    assign if_rvalid_o = if_rvalid_r;
    assign d_rvalid_o  = d_rvalid_r;
    assign if_rdata_o  = if_rdata_r;
    assign d_rdata_o   = d_rdata_r;
    assign mem_we_o    = we_r;
    assign mem_addr_o  = addr_r;
    assign mem_wdata_o = wdata_r;
    assign busy_o      = busy_r;

`ifdef MEM_ARB_PERF_EN
    logic [15:0] conflict_cnt_r;
    logic [15:0] if_cnt_r;
    logic [15:0] d_cnt_r;
    logic        conflict_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    assign conflict_s = (state_r == ST_IDLE) && if_req_i && d_req_i;

    // Saturating performance counters, bumped on the same edges the grants are decided.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            conflict_cnt_r <= 16'd0;
            if_cnt_r       <= 16'd0;
            d_cnt_r        <= 16'd0;
        end else begin
            if (conflict_s) begin
                conflict_cnt_r <= sat_inc(conflict_cnt_r);
            end else begin
                conflict_cnt_r <= conflict_cnt_r;
            end
            if (if_gnt_s) begin
                if_cnt_r <= sat_inc(if_cnt_r);
            end else begin
                if_cnt_r <= if_cnt_r;
            end
            if (d_gnt_s) begin
                d_cnt_r <= sat_inc(d_cnt_r);
            end else begin
                d_cnt_r <= d_cnt_r;
            end
        end
    end

    assign conflict_cnt_o = conflict_cnt_r;
    assign if_cnt_o       = if_cnt_r;
    assign d_cnt_o        = d_cnt_r;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed test-plan steps plus random traffic
// against a transaction-level reference model and a small word-addressed memory.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] conflict_cnt, if_cnt, d_cnt;
`endif

    mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy)
`ifdef MEM_ARB_PERF_EN
        , .conflict_cnt_o(conflict_cnt), .if_cnt_o(if_cnt), .d_cnt_o(d_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory system: combinational read, write on the rising edge; preload port for setup.
    logic [31:0] sys_mem [64];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_val = 32'd0;
    assign mem_rdata = sys_mem[mem_addr[7:2]];
    always @(posedge CLK) begin
        if (pre_en) sys_mem[pre_idx] <= pre_val;
        else if (mem_we) sys_mem[mem_addr[7:2]] <= mem_wdata;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: what the memory should hold and what each port should see next.
    logic [31:0] ref_mem [64];
    bit          m_busy, m_last_d, m_owner_d, m_we;
    logic [31:0] m_addr, m_wdata;
    int          m_conf, m_ni, m_nd;
    bit          grant_log[$];
    logic        e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_busy, e_we;
    logic [31:0] e_if_rdata, e_d_rdata, e_addr, e_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_last_d = 1'b1; m_owner_d = 1'b0; m_we = 1'b0;
        m_addr = 32'd0; m_wdata = 32'd0; m_conf = 0; m_ni = 0; m_nd = 0;
        e_if_gnt = 1'b0; e_d_gnt = 1'b0; e_if_rv = 1'b0; e_d_rv = 1'b0;
        e_busy = 1'b0; e_we = 1'b0; e_if_rdata = 32'd0; e_d_rdata = 32'd0;
        e_addr = 32'd0; e_wdata = 32'd0;
        grant_log.delete();
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit win_d;
        e_if_gnt = 1'b0; e_d_gnt = 1'b0; e_if_rv = 1'b0; e_d_rv = 1'b0;
        e_busy = 1'b0; e_we = 1'b0;
        if (m_busy) begin
            m_busy = 1'b0;
            if (!m_owner_d) begin
                e_if_rv = 1'b1;
                e_if_rdata = ref_mem[m_addr[7:2]];
            end else begin
                e_d_rv = 1'b1;
                if (m_we) ref_mem[m_addr[7:2]] = m_wdata;
                else e_d_rdata = ref_mem[m_addr[7:2]];
            end
        end else if (if_req || d_req) begin
            if (if_req && d_req) begin
                win_d = !m_last_d;
                m_conf++;
            end else begin
                win_d = d_req;
            end
            m_last_d = win_d; m_owner_d = win_d; m_busy = 1'b1; e_busy = 1'b1;
            grant_log.push_back(win_d);
            if (win_d) begin
                e_d_gnt = 1'b1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_nd++;
            end else begin
                e_if_gnt = 1'b1; m_we = 1'b0; m_addr = if_addr; m_wdata = 32'd0; m_ni++;
            end
            e_we = m_we; e_addr = m_addr; e_wdata = m_wdata;
        end
    endtask

    task automatic check_all();
        chk("if_gnt", 32'(if_gnt), 32'(e_if_gnt));
        chk("d_gnt", 32'(d_gnt), 32'(e_d_gnt));
        chk("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
        chk("d_rvalid", 32'(d_rvalid), 32'(e_d_rv));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [31:0] da, input logic [31:0] dd);
        if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        @(negedge CLK);
        check_all();
    endtask

    task automatic do_reset();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        RST_n = 1'b0;
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        check_all();
        RST_n = 1'b1;
    endtask

    initial begin
        logic [31:0] saved;
        // Fill memory while held in reset.
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            pre_en = 1'b1; pre_idx = 6'(i);
            pre_val = (i == 0) ? 32'h2008_0005 : (32'hA500_0000 | 32'(i));
            ref_mem[i] = pre_val;
        end
        @(negedge CLK);
        pre_en = 1'b0;
        do_reset();

        // IF alone.
        drive(1'b1, 32'h0040_0000, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk("t1_if_gnt", 32'(if_gnt), 32'd1);
        chk("t1_mem_we", 32'(mem_we), 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk("t1_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("t1_if_rdata", if_rdata, 32'h2008_0005);

        // D write then read back.
        drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF);
        step();
        chk("t2_mem_we", 32'(mem_we), 32'd1);
        chk("t2_mem_addr", mem_addr, 32'h1001_0004);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk("t2_d_rvalid", 32'(d_rvalid), 32'd1);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h1001_0004, 32'd0);
        step();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk("t2_d_rdata", d_rdata, 32'hDEAD_BEEF);

        // Both held from reset: IF, D, IF, D.
        do_reset();
        drive(1'b1, 32'h0040_0008, 1'b1, 1'b0, 32'h1001_0004, 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t3_one_gnt", 32'(if_gnt & d_gnt), 32'd0);
            chk("t3_one_rvalid", 32'(if_rvalid & d_rvalid), 32'd0);
        end
        chk("t3_ngrants", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk("t3_order", 32'(grant_log[i]), 32'(i % 2));
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();

        // IF drops its request on the cycle it would be sampled; only D proceeds.
        drive(1'b1, 32'h0040_0000, 1'b1, 1'b0, 32'h1001_0004, 32'd0);
        step();
        step();
        drive(1'b0, 32'h0040_0000, 1'b1, 1'b0, 32'h1001_0004, 32'd0);
        step();
        chk("t4_d_gnt", 32'(d_gnt), 32'd1);
        chk("t4_if_gnt", 32'(if_gnt), 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        step();

        // Reset in the middle of a D write access.
        saved = ref_mem[2];
        drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h1001_0008, 32'h1234_5678);
        step();
        chk("t5_we_before", 32'(mem_we), 32'd1);
        #1;
        RST_n = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        model_reset();
        #1;
        chk("t5_we_dropped", 32'(mem_we), 32'd0);
        check_all();
        @(posedge CLK);
        @(negedge CLK);
        check_all();
        chk("t5_mem_kept", sys_mem[2], saved);
        RST_n = 1'b1;
        drive(1'b1, 32'h0040_0004, 1'b1, 1'b0, 32'h1001_0008, 32'd0);
        step();
        chk("t5_first_tie_if", 32'(if_gnt), 32'd1);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();

`ifdef MEM_ARB_PERF_EN
        // Ten contended accesses from reset.
        do_reset();
        drive(1'b1, 32'h0040_0000, 1'b1, 1'b0, 32'h1001_0004, 32'd0);
        for (int i = 0; i < 20; i++) step();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk("perf_conflict_nz", 32'(conflict_cnt != 16'd0), 32'd1);
        chk("perf_conflict", 32'(conflict_cnt), 32'(m_conf));
        chk("perf_if_cnt", 32'(if_cnt), 32'd5);
        chk("perf_d_cnt", 32'(d_cnt), 32'd5);
`endif

        // Random traffic, including withdrawals, misaligned addresses and input churn.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 1)), $urandom, $urandom);
            step();
        end
`ifdef MEM_ARB_PERF_EN
        chk("rand_if_cnt", 32'(if_cnt), 32'(m_ni));
        chk("rand_d_cnt", 32'(d_cnt), 32'(m_nd));
        chk("rand_conflict", 32'(conflict_cnt), 32'(m_conf));
`endif
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        step();
        for (int i = 0; i < 64; i++) chk("final_mem", sys_mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
